// File: rtl/sw_host_driver.sv
// Host-side driver for a Smith-Waterman accelerator. Holds a query and a
// database sequence buffer written by the host, and on request streams both
// buffers to the accelerator in lockstep. It then waits for the score,
// giving up after a bounded number of cycles.
module sw_host_driver #(
    parameter int SEQ_BYTES = 4,     // packed sequence bytes per run, 1..8
    parameter int TIMEOUT   = 1023   // max cycles to wait for a result, 1..65535
) (
    input  logic       clk,
    input  logic       rst_n,
    // host buffer write port
    input  logic       wr_en,
    input  logic       wr_sel,
    input  logic [2:0] wr_addr,
    input  logic [7:0] wr_data,
    // host control / status
    input  logic       go,
    output logic       busy,
    output logic       done,
    output logic [6:0] score_out,
    output logic       timeout_err,
    // accelerator side
    input  logic       sw_ready,
    output logic       sw_start,
    output logic [7:0] sw_query_seq,
    output logic [7:0] sw_database_seq,
    input  logic       sw_output_valid,
    input  logic [6:0] sw_score
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_RDY,
        S_START,
        S_STREAM,
        S_WAIT_RES,
        S_DONE
    } state_t;

    localparam logic [2:0]  LAST_IDX = 3'(SEQ_BYTES - 1);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [3:0]  NUM_BYTES = 4'(SEQ_BYTES);

    state_t      state;
    logic [2:0]  idx;
    logic [15:0] cnt;
    logic [7:0]  query_buf [8];
    logic [7:0]  db_buf    [8];
    logic        wr_ok;

    // A write lands only while idle and inside the active sequence length.
    assign wr_ok = wr_en && !busy && ({1'b0, wr_addr} < NUM_BYTES);

    // Host-writable sequence buffers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: these are small register files, not RAM macros, so they can and must be cleared on reset.
            for (int i = 0; i < 8; i++) begin
                query_buf[i] <= 8'h00;
                db_buf[i]    <= 8'h00;
            end
        end else if (wr_ok) begin
            if (wr_sel) db_buf[wr_addr]    <= wr_data;
            else        query_buf[wr_addr] <= wr_data;
        end
    end

    // Run sequencer; every output is registered and set on entry to the state that owns it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            sw_start        <= 1'b0;
            timeout_err     <= 1'b0;
            score_out       <= 7'd0;
            sw_query_seq    <= 8'h00;
            sw_database_seq <= 8'h00;
            idx             <= 3'd0;
            cnt             <= 16'd0;
        end else begin
            // NOTE: pulse outputs default low each cycle; non-blocking so every branch sees pre-edge state.
            done     <= 1'b0;
            sw_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go) begin
                        state       <= S_WAIT_RDY;
                        busy        <= 1'b1;
                        timeout_err <= 1'b0;
                    end
                end
                S_WAIT_RDY: begin
                    if (sw_ready) begin
                        state           <= S_START;
                        sw_start        <= 1'b1;
                        sw_query_seq    <= query_buf[0];
                        sw_database_seq <= db_buf[0];
                    end
                end
                S_START: begin
                    if (SEQ_BYTES == 1) begin
                        state           <= S_WAIT_RES;
                        sw_query_seq    <= 8'h00;
                        sw_database_seq <= 8'h00;
                        cnt             <= 16'd0;
                    end else begin
                        state           <= S_STREAM;
                        idx             <= 3'd1;
                        sw_query_seq    <= query_buf[1];
                        sw_database_seq <= db_buf[1];
                    end
                end
                S_STREAM: begin
                    if (idx == LAST_IDX) begin
                        state           <= S_WAIT_RES;
                        sw_query_seq    <= 8'h00;
                        sw_database_seq <= 8'h00;
                        cnt             <= 16'd0;
                    end else begin
                        idx             <= idx + 3'd1;
                        sw_query_seq    <= query_buf[idx + 3'd1];
                        sw_database_seq <= db_buf[idx + 3'd1];
                    end
                end
                S_WAIT_RES: begin
                    // A result arriving on the last allowed cycle still counts.
                    if (sw_output_valid) begin
                        score_out <= sw_score;
                        state     <= S_DONE;
                        done      <= 1'b1;
                    end else if (cnt == TO_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= S_DONE;
                        done        <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state           <= S_IDLE;
                    busy            <= 1'b0;
                    sw_query_seq    <= 8'h00;
                    sw_database_seq <= 8'h00;
                end
            endcase
        end
    end

endmodule
